// File: rtl/imem_responder_pkg.sv
// Shared constants and state encoding for the instruction-memory responder.
package imem_responder_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH = 10;
  localparam int unsigned IMEM_DATA_W     = 32;
  localparam logic [31:0] IMEM_NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_STATE_READY = 2'd0,
    IMEM_STATE_LOAD  = 2'd1,
    IMEM_STATE_FLUSH = 2'd2
  } imem_state_e;

endpackage : imem_responder_pkg

// File: rtl/imem_responder_array.sv
// DEPTH x DATA_W storage: one write port, one synchronous read port whose
// output register can be loaded with CLR_VALUE instead of array data.
module imem_responder_array #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] CLR_VALUE = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_clr)     rd_data_d = DATA_W'(CLR_VALUE);
    else if (rd_en) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= DATA_W'(CLR_VALUE);
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule : imem_responder_array

// File: rtl/imem_responder.sv
// Instruction-fetch responder: 1-cycle registered fetch with range/alignment
// error decode, plus a streaming program-load port that fills from word 0.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter logic [31:0] NOP_INSTR  = IMEM_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           fetch_addr,
  input  logic                  fetch_hold,
  output logic [31:0]           inst_out,
  output logic                  mem_error,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-2:0] load_count
);

  localparam int unsigned PTR_W = ADDR_WIDTH - 2;
  localparam int unsigned CNT_W = ADDR_WIDTH - 1;
  localparam int unsigned DEPTH = 1 << PTR_W;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  imem_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] load_count_q, load_count_d;
  logic             load_ready_q, load_ready_d;
  logic             busy_q, busy_d;
  logic             mem_error_q, mem_error_d;

  logic rd_en, rd_clr, wr_en, fetch_err, final_wr;

  assign fetch_err = (|fetch_addr[31:ADDR_WIDTH]) | (|fetch_addr[1:0]);
  assign final_wr  = load_last || (ptr_q == PTR_MAX);

  // Next-state, pointer/count and read-port control.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    load_ready_d = load_ready_q;
    busy_d       = busy_q;
    mem_error_d  = mem_error_q;
    rd_en        = 1'b0;
    rd_clr       = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IMEM_STATE_READY: begin
        if (load_start) begin
          state_d      = IMEM_STATE_LOAD;
          ptr_d        = '0;
          load_count_d = '0;
          load_ready_d = 1'b1;
          busy_d       = 1'b1;
          mem_error_d  = 1'b0;
          rd_clr       = 1'b1;
        end else if (!fetch_hold) begin
          rd_en       = 1'b1;
          rd_clr      = fetch_err;
          mem_error_d = fetch_err;
        end
      end
      IMEM_STATE_LOAD: begin
        rd_clr      = 1'b1;
        mem_error_d = 1'b0;
        if (load_valid && load_ready_q) begin
          wr_en        = 1'b1;
          load_count_d = load_count_q + CNT_W'(1);
          // Pointer stops at the last word instead of wrapping.
          if (ptr_q != PTR_MAX) ptr_d = ptr_q + PTR_W'(1);
          if (final_wr) begin
            load_ready_d = 1'b0;
            state_d      = IMEM_STATE_FLUSH;
          end
        end
      end
      IMEM_STATE_FLUSH: begin
        rd_clr       = 1'b1;
        mem_error_d  = 1'b0;
        load_ready_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IMEM_STATE_READY;
      end
      default: begin
        rd_clr       = 1'b1;
        mem_error_d  = 1'b0;
        load_ready_d = 1'b0;
        busy_d       = 1'b0;
        state_d      = IMEM_STATE_READY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IMEM_STATE_READY;
      ptr_q        <= '0;
      load_count_q <= '0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      mem_error_q  <= mem_error_d;
    end
  end

  imem_responder_array #(
    .DEPTH    (DEPTH),
    .ADDR_W   (PTR_W),
    .DATA_W   (32),
    .CLR_VALUE(NOP_INSTR)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .rd_addr(fetch_addr[ADDR_WIDTH-1:2]),
    .rd_data(inst_out),
    .wr_en  (wr_en),
    .wr_addr(ptr_q),
    .wr_data(load_data)
  );

  assign mem_error  = mem_error_q;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign load_count = load_count_q;

endmodule : imem_responder
